// File: rtl/demod_slicer_pkg.sv
// Shared types and default sizing for the demod symbol slicer.
package demod_slicer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SPS        = 8;
  localparam int DEF_ACC_W      = 40;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SPS);

endpackage

// File: rtl/demod_slicer_fifo.sv
// Small synchronous FIFO for packed slicer words; a push into a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module demod_slicer_fifo
  import demod_slicer_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = cnt_width(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr_reg, rd_ptr_reg;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

  // Head is forced to zero while empty so stale storage never shows.
  assign head = empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/demod_symbol_slicer.sv
// Integrate-and-dump symbol slicer with bit packing and output FIFO.
// Define SLICER_LSB_FIRST_EN to pack the first decided bit into out_word[0].
module demod_symbol_slicer
  import demod_slicer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SPS        = DEF_SPS,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] threshold,
  input  logic              sync_req,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = cnt_width(SPS);
  localparam int BIT_W = cnt_width(WORD_W);
  localparam logic signed [ACC_W-1:0] SPS_A = ACC_W'(SPS);

  state_t                   state_reg, state_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]         sample_cnt_reg, sample_cnt_next;
  logic [BIT_W-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0]        shift_reg, shift_next;
  logic                     pend_reg, pend_next;
  logic [WORD_W-1:0]        pend_word_reg, pend_word_next;
  logic                     overflow_reg, overflow_next;

  logic signed [ACC_W-1:0]  in_ext, thr_ext, thr_scaled, total;
  logic                     decided_bit;
  logic [WORD_W-1:0]        shift_in, packed_word;
  logic                     fifo_full, fifo_empty;

  assign in_ext      = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign thr_ext     = {{(ACC_W-DATA_W){threshold[DATA_W-1]}}, threshold};
  assign thr_scaled  = thr_ext * SPS_A;
  assign total       = acc_reg + in_ext;
  assign decided_bit = (total > thr_scaled);
  assign shift_in    = {shift_reg[WORD_W-2:0], decided_bit};

`ifdef SLICER_LSB_FIRST_EN
  // The shift register always holds the first bit at the top; mirror it.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_rev
    assign packed_word[gi] = shift_in[WORD_W-1-gi];
  end
`else
  assign packed_word = shift_in;
`endif

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    sample_cnt_next = sample_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    pend_next       = 1'b0;
    pend_word_next  = pend_word_reg;
    // With the FIFO full it cannot be empty, so a pop depends only on out_ready.
    overflow_next   = overflow_reg | (pend_reg && fifo_full && !out_ready);

    if (sync_req) begin
      state_next      = IDLE;
      acc_next        = '0;
      sample_cnt_next = '0;
      bit_cnt_next    = '0;
      shift_next      = '0;
    end else if (in_valid) begin
      state_next = ACCUM;
      if (sample_cnt_reg == CNT_W'(SPS-1)) begin
        acc_next        = '0;
        sample_cnt_next = '0;
        shift_next      = shift_in;
        if (bit_cnt_reg == BIT_W'(WORD_W-1)) begin
          bit_cnt_next   = '0;
          pend_next      = 1'b1;
          pend_word_next = packed_word;
        end else begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        end
      end else begin
        acc_next        = total;
        sample_cnt_next = sample_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      pend_reg       <= 1'b0;
      pend_word_reg  <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      sample_cnt_reg <= sample_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      pend_reg       <= pend_next;
      pend_word_reg  <= pend_word_next;
      overflow_reg   <= overflow_next;
    end
  end

  demod_slicer_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_reg),
    .push_data (pend_word_reg),
    .pop       (out_ready),
    .head      (out_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_reg;
  assign busy      = (state_reg == ACCUM);

endmodule

// File: doc/demod_symbol_slicer.md
Name: demod_symbol_slicer

Overview:
- Downstream consumer of the demodulation if-stage: takes its registered 32-bit demodulated sample stream.
- Integrates SPS samples per symbol (integrate-and-dump) and slices each symbol to one bit against a programmable threshold.
- Packs bits into bytes and buffers them in a small FIFO with a valid/ready output toward the framing/deframer stage.

Parameters:
- DATA_W, 32: input sample width, signed two's complement.
- SPS, 8: samples per symbol, 2..256.
- ACC_W, 40: accumulator width; must be >= DATA_W + clog2(SPS).
- WORD_W, 8: bits per packed output word.
- FIFO_DEPTH, 4: output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- in_data  in  DATA_W  signed demodulated sample (demodulated_out_1 of the if-stage).
- in_valid  in  1  in_data valid this cycle; no input backpressure exists.
- threshold  in  DATA_W  signed decision threshold; sampled at each decision.
- sync_req  in  1  symbol-timing restart pulse.
- out_word  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_word when out_valid && out_ready.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- busy  out  1  FSM in ACCUM.

Behaviour:
- Reset (reset==0 at a clk edge) clears everything: state=IDLE, acc=0, sample_cnt=0, bit_cnt=0, shift=0, FIFO empty, out_valid=0, out_word=0, overflow=0, busy=0. Reset mid-symbol or mid-word discards all partial data.
- FSM states:
  - IDLE → ACCUM on the first in_valid; that sample is accumulated.
  - ACCUM stays in ACCUM; it returns to IDLE only on sync_req or reset.
- Accumulate: on each accepted sample, acc_next = acc + sign_extend(in_data); sample_cnt increments.
- Decision: on the SPS-th sample (sample_cnt==SPS-1), compute total = acc + sign_extend(in_data).
  - bit = (total > sign_extend(threshold) * SPS), signed compare, multiply done at ACC_W.
  - Same edge: acc←0, sample_cnt←0, bit shifted into shift register MSB-first (first bit lands in out_word[WORD_W-1]), bit_cnt increments.
- Word completion: when the WORD_W-th bit is decided at edge N, the packed word is written to the FIFO at edge N+1 and bit_cnt←0.
  - out_valid rises after edge N+1 if the FIFO was empty.
  - Latency from last sample of the word to out_valid: 2 edges.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push with FIFO full and no pop in the same cycle: word dropped, overflow←1 (cleared only by reset).
  - Push and pop in the same cycle while full: both occur and no overflow.
  - out_word holds the head word steadily while out_valid && !out_ready.
- sync_req (one cycle): acc, sample_cnt, bit_cnt and shift clear; state←IDLE. The FIFO, any pending word write and overflow are kept.
  - sync_req together with in_valid: sync wins and the sample is discarded.
- Arithmetic: no saturation; ACC_W is sized so no wrap occurs. Threshold == total gives bit 0.

Optional Feature:
- SLICER_LSB_FIRST_EN defined: bits pack LSB-first (first decided bit goes to out_word[0]).
- Undefined: MSB-first as above. All timing is identical in both cases.

Decomposition:
- Package demod_slicer_pkg holds:
  - State enum (IDLE, ACCUM).
  - Default-width localparams.
  - A clog2-based sample-counter width constant.
- Sub-module demod_slicer_fifo: synchronous FIFO, DEPTH x WORD_W, with push/pop/full/empty and push-pop-when-full support.

Test Plan (all use SPS=8, WORD_W=8, threshold=0):
- Reset: 64 valid samples of +100 → out_valid=0, overflow=0 throughout.
- Alternating symbols: 8 symbols alternating +100 x8 / -100 x8, starting positive, with out_ready=1 → out_word=0xAA, out_valid 2 edges after the 64th sample. With SLICER_LSB_FIRST_EN → 0x55.
- Tie and threshold: threshold=50 with samples +50 x8 → bit 0. Samples +51 x8 → bit 1. Eight symbols of +51 → 0xFF.
- Overflow: out_ready=0, 5 words of 0x0F pattern → 4 in FIFO, overflow=1. Then out_ready=1 → four 0x0F pops, overflow stays 1.
- Sync mid-symbol: 5 samples of -100, sync_req (with in_valid, sample dropped), then 64 samples of +7 → out_word=0xFF, with no stale negative contribution.
- Full push/pop: FIFO full, and a word completes in the same cycle as out_ready=1 → count stays 4, overflow=0, order preserved.
